// File: rtl/fact_seq.sv
`timescale 1ns/1ps
// fact_seq: sequencer for the factorial unit.
// Accepts an operand on a go/done handshake and computes n! by repeated
// multiplication with a down-counter. The counter is compared against 1 by
// an external comparator (CMP), whose GT flag is consumed combinationally.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   go      start request (level); must drop between operations
//   n       operand, sampled only when a start is accepted
//   cmp_gt  GT flag from CMP for cmp_a > cmp_b
//   cmp_a   current counter value (CMP A input)
//   cmp_b   constant 1 (CMP B input)
//   busy    high while computing (CHECK, MULT)
//   done    high in DONE; result valid
//   err     high in ERR (operand above NMAX)
//   result  factorial of the last completed operation
module fact_seq #(
  parameter int unsigned NMAX = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [3:0]  n,
  input  logic        cmp_gt,
  output logic [3:0]  cmp_a,
  output logic [3:0]  cmp_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MULT,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic [31:0] res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if ({28'd0, n} > NMAX) begin
            state_d = S_ERR;
          end else begin
            cnt_d   = n;
            prod_d  = 32'd1;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        // cmp_gt reflects cnt_q > 1 in this same cycle
        if (cmp_gt) begin
          state_d = S_MULT;
        end else begin
          res_d   = prod_q;
          state_d = S_DONE;
        end
      end
      S_MULT: begin
        prod_d  = prod_q * {28'd0, cnt_q};
        cnt_d   = cnt_q - 4'd1;
        state_d = S_CHECK;
      end
      S_DONE, S_ERR: begin
        if (!go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmp_a  = cnt_q;
  assign cmp_b  = 4'd1;
  assign busy   = (state_q == S_CHECK) || (state_q == S_MULT);
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_ERR);
  assign result = res_q;

endmodule
